ets_stream_sink: RTL and testbench



---
 rtl/ets_stream_sink.sv | 195 +++++++++++++++++++
 tb/tb_ets_stream_sink.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ets_stream_sink.sv
// AXI4-Stream sink: captures one tlast-delimited ETS frame into a buffer, checks its length, holds it for readout.
// Define ETS_SINK_TKEEP_CHECK_EN to flag frames containing partial tkeep beats.
module ets_stream_sink #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    S_AXIS_aclk,
    input  logic                    S_AXIS_areset,
    input  logic                    S_AXIS_tvalid,
    output logic                    S_AXIS_tready,
    input  logic [DATA_WIDTH-1:0]   S_AXIS_tdata,
    input  logic [DATA_WIDTH/8-1:0] S_AXIS_tkeep,
    input  logic                    S_AXIS_tlast,
    input  logic                    arm,
    input  logic [ADDR_WIDTH:0]     expected_len,
    input  logic                    frame_ack,
    output logic                    frame_done,
    output logic [ADDR_WIDTH:0]     frame_len,
    output logic                    len_err,
    output logic                    overflow,
    output logic                    keep_err,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic [15:0]             frame_count,
    output logic [15:0]             err_count
);

    localparam logic [ADDR_WIDTH:0]     FULL_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]     ZERO_LEN = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]     ONE_LEN  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH/8-1:0] KEEP_ALL = {(DATA_WIDTH/8){1'b1}};
`ifdef ETS_SINK_TKEEP_CHECK_EN
    localparam logic KEEP_CHECK_EN = 1'b1;
`else
    localparam logic KEEP_CHECK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DROP    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    tready_q, tready_d;
    logic                    frame_done_q, frame_done_d;
    logic [ADDR_WIDTH:0]     frame_len_q, frame_len_d;
    logic                    len_err_q, len_err_d;
    logic                    overflow_q, overflow_d;
    logic                    keep_err_q, keep_err_d;
    logic [15:0]             frame_count_q, frame_count_d;
    logic [15:0]             err_count_q, err_count_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0]   mem_q [0:(1<<ADDR_WIDTH)-1];

    logic                    hs;
    logic                    keep_bad;
    logic                    start;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;

    assign hs       = S_AXIS_tvalid & tready_q;
    assign keep_bad = KEEP_CHECK_EN & (S_AXIS_tkeep != KEEP_ALL);
    // Capture opens from IDLE on arm, or straight out of DONE when ack and arm coincide.
    assign start    = arm & ((state_q == IDLE) | ((state_q == DONE) & frame_ack));

    // State register
    always_ff @(posedge S_AXIS_aclk) begin
        if (S_AXIS_areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (arm) state_d = CAPTURE;
                else     state_d = IDLE;
            end
            CAPTURE: begin
                if (hs && S_AXIS_tlast)              state_d = DONE;
                else if (hs && frame_len_q == FULL_LEN) state_d = DROP;
                else                                 state_d = CAPTURE;
            end
            DROP: begin
                if (hs && S_AXIS_tlast) state_d = DONE;
                else                    state_d = DROP;
            end
            DONE: begin
                if (frame_ack && arm) state_d = CAPTURE;
                else if (frame_ack)   state_d = IDLE;
                else                  state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state so tready/frame_done are registered alongside it
    always_comb begin
        tready_d     = (state_d == CAPTURE) || (state_d == DROP);
        frame_done_d = (state_d == DONE);
    end

    // Frame length, error flags, counters and buffer write control
    always_comb begin
        frame_len_d   = frame_len_q;
        len_err_d     = len_err_q;
        overflow_d    = overflow_q;
        keep_err_d    = keep_err_q;
        frame_count_d = frame_count_q;
        err_count_d   = err_count_q;
        wr_en         = 1'b0;
        wr_addr       = frame_len_q[ADDR_WIDTH-1:0];
        if (start) begin
            frame_len_d = ZERO_LEN;
            len_err_d   = 1'b0;
            overflow_d  = 1'b0;
            keep_err_d  = 1'b0;
        end else if (hs) begin
            keep_err_d = keep_err_q | keep_bad;
            if ((state_q == CAPTURE) && (frame_len_q != FULL_LEN)) begin
                wr_en       = 1'b1;
                frame_len_d = frame_len_q + ONE_LEN;
            end else begin
                overflow_d = 1'b1;
            end
        end else begin
            frame_len_d = frame_len_q;
        end
        // Frame completion: evaluated on the final length so flags and counters land with frame_done
        if ((state_q != DONE) && (state_d == DONE)) begin
            len_err_d     = (expected_len != ZERO_LEN) && (frame_len_d != expected_len);
            frame_count_d = frame_count_q + 16'd1;
            if (len_err_d || overflow_d || keep_err_d) err_count_d = err_count_q + 16'd1;
            else                                      err_count_d = err_count_q;
        end else begin
            frame_count_d = frame_count_q;
        end
    end

    // Read port: holds its value when not strobed; old data on same-address collision
    always_comb begin
        if (rd_en) rd_data_d = mem_q[rd_addr];
        else       rd_data_d = rd_data_q;
    end

    // Registered outputs and datapath state
    always_ff @(posedge S_AXIS_aclk) begin
        if (S_AXIS_areset) begin
            tready_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_len_q   <= ZERO_LEN;
            len_err_q     <= 1'b0;
            overflow_q    <= 1'b0;
            keep_err_q    <= 1'b0;
            frame_count_q <= 16'd0;
            err_count_q   <= 16'd0;
            rd_data_q     <= {DATA_WIDTH{1'b0}};
        end else begin
            tready_q      <= tready_d;
            frame_done_q  <= frame_done_d;
            frame_len_q   <= frame_len_d;
            len_err_q     <= len_err_d;
            overflow_q    <= overflow_d;
            keep_err_q    <= keep_err_d;
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // Frame buffer write port (contents are not reset)
    always_ff @(posedge S_AXIS_aclk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= S_AXIS_tdata;
        end
    end

    assign S_AXIS_tready = tready_q;
    assign frame_done    = frame_done_q;
    assign frame_len     = frame_len_q;
    assign len_err       = len_err_q;
    assign overflow      = overflow_q;
    assign keep_err      = keep_err_q;
    assign frame_count   = frame_count_q;
    assign err_count     = err_count_q;
    assign rd_data       = rd_data_q;

endmodule

// File: tb/tb_ets_stream_sink.sv
// Scoreboard bench for ets_stream_sink: randomized frames checked against a frame-level reference model.
module tb_ets_stream_sink;
    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;
`ifdef ETS_SINK_TKEEP_CHECK_EN
    localparam bit KEEP_EN = 1'b1;
`else
    localparam bit KEEP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic          tvalid = 1'b0, tready, tlast = 1'b0;
    logic [31:0]   tdata = 32'd0;
    logic [3:0]    tkeep = 4'hF;
    logic          arm = 1'b0, frame_ack = 1'b0, frame_done;
    logic [AW:0]   expected_len = '0, frame_len;
    logic          len_err, overflow, keep_err;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [31:0]   rd_data;
    logic [15:0]   frame_count, err_count;

    always #5 clk = ~clk;

    ets_stream_sink #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
        .S_AXIS_aclk(clk), .S_AXIS_areset(areset), .S_AXIS_tvalid(tvalid), .S_AXIS_tready(tready),
        .S_AXIS_tdata(tdata), .S_AXIS_tkeep(tkeep), .S_AXIS_tlast(tlast),
        .arm(arm), .expected_len(expected_len), .frame_ack(frame_ack), .frame_done(frame_done),
        .frame_len(frame_len), .len_err(len_err), .overflow(overflow), .keep_err(keep_err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_count(frame_count), .err_count(err_count)
    );

    typedef struct {
        int          len;
        bit          le;
        bit          ov;
        bit          ke;
        logic [15:0] fc;
        logic [15:0] ec;
    } fexp_t;

    fexp_t       fr_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] mem_m [DEPTH];
    logic [15:0] fc_m = 16'd0, ec_m = 16'd0;
    int          vectors = 0, miscompares = 0;
    int          last_flen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a read result or a completed frame
    logic [31:0] last_rd = 32'd0;
    bit          prev_done = 1'b0, rd_pend = 1'b0;
    fexp_t       mon_e;
    always @(negedge clk) begin
        if (areset) begin
            prev_done = 1'b0;
            rd_pend   = 1'b0;
            last_rd   = 32'd0;
        end else begin
            if (rd_pend) begin
                if (rd_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL rd_unexpected: got read data 0x%0h with no read expected", rd_data);
                end else begin
                    last_rd = rd_q.pop_front();
                    check("rd_data", rd_data, last_rd);
                end
            end else begin
                check("rd_hold", rd_data, last_rd);
            end
            rd_pend = rd_en;
            if (frame_done && !prev_done) begin
                if (fr_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL frame_unexpected: frame_done rose with no frame expected");
                end else begin
                    mon_e = fr_q.pop_front();
                    check("frame_len",   frame_len,   mon_e.len);
                    check("len_err",     len_err,     mon_e.le);
                    check("overflow",    overflow,    mon_e.ov);
                    check("keep_err",    keep_err,    mon_e.ke);
                    check("frame_count", frame_count, mon_e.fc);
                    check("err_count",   err_count,   mon_e.ec);
                    check("tready_done", tready,      32'd0);
                end
            end
            prev_done = frame_done;
        end
    end

    task automatic check_reset_values();
        check("rst_tready", tready, 32'd0);
        check("rst_frame_done", frame_done, 32'd0);
        check("rst_frame_len", frame_len, 32'd0);
        check("rst_len_err", len_err, 32'd0);
        check("rst_overflow", overflow, 32'd0);
        check("rst_keep_err", keep_err, 32'd0);
        check("rst_frame_count", frame_count, 32'd0);
        check("rst_err_count", err_count, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
    endtask

    task automatic arm_frame(input int ex);
        @(posedge clk); #1; expected_len = ex[AW:0]; arm = 1'b1;
        @(posedge clk); #1; arm = 1'b0;
        @(negedge clk);
        check("tready_after_arm", tready, 32'd1);
    endtask

    // Reference model: a frame of n beats keeps its first min(n,DEPTH) words and is judged as a whole
    task automatic send_frame(input int n, input int bad_idx, input int gap, input bit rnd, input logic [31:0] base);
        logic [31:0] w[$];
        fexp_t       e;
        int          i, budget;
        for (int k = 0; k < n; k++) w.push_back(rnd ? $urandom : base + k);
        e.len = (n > DEPTH) ? DEPTH : n;
        for (int k = 0; k < e.len; k++) mem_m[k] = w[k];
        e.ov  = (n > DEPTH);
        e.ke  = KEEP_EN && (bad_idx >= 0) && (bad_idx < n);
        e.le  = (expected_len != 0) && (e.len != int'(expected_len));
        fc_m  = fc_m + 16'd1;
        if (e.le || e.ov || e.ke) ec_m = ec_m + 16'd1;
        e.fc  = fc_m;
        e.ec  = ec_m;
        fr_q.push_back(e);
        last_flen = e.len;
        i = 0;
        budget = 0;
        while (i < n) begin
            @(posedge clk); #1;
            if (gap > 0 && $urandom_range(99) < gap) begin
                tvalid = 1'b0;
            end else begin
                tvalid = 1'b1; tdata = w[i]; tlast = (i == n - 1);
                tkeep  = (i == bad_idx) ? 4'h7 : 4'hF;
            end
            @(negedge clk);
            if (tvalid && tready) i++;
            budget++;
            if (budget > 4000) begin
                vectors++; miscompares++;
                $display("FAIL beat_timeout: accepted %0d beats, required %0d", i, n);
                break;
            end
        end
        @(posedge clk); #1; tvalid = 1'b0; tlast = 1'b0; tkeep = 4'hF;
    endtask

    task automatic wait_done();
        int t = 0;
        @(negedge clk);
        while (!frame_done && t < 500) begin @(negedge clk); t++; end
        if (!frame_done) begin
            vectors++; miscompares++;
            $display("FAIL done_timeout: frame_done=%0b, required 1", frame_done);
        end
    endtask

    // Reads the held frame while upstream offers junk, which must not be accepted in DONE
    task automatic hold_and_read(input int first);
        @(posedge clk); #1; tvalid = 1'b1; tdata = 32'hDEAD_BEEF; tlast = 1'b1;
        if (first >= 0 && first < last_flen) begin
            rd_en = 1'b1; rd_addr = AW'(first); rd_q.push_back(mem_m[first]);
            @(posedge clk); #1; rd_en = 1'b0;
        end
        for (int i = 0; i < last_flen; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(3) == 0) begin rd_en = 1'b0; @(posedge clk); #1; end
            rd_en = 1'b1; rd_addr = AW'(i); rd_q.push_back(mem_m[i]);
        end
        @(posedge clk); #1; rd_en = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("len_hold_done", frame_len, last_flen);
        check("done_hold", frame_done, 32'd1);
        @(posedge clk); #1; tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic ack_frame(input bit rearm, input int next_ex);
        @(posedge clk); #1; frame_ack = 1'b1; arm = rearm; expected_len = next_ex[AW:0];
        @(posedge clk); #1; frame_ack = 1'b0; arm = 1'b0;
        @(negedge clk);
        check("tready_after_ack", tready, {31'd0, rearm});
        check("done_after_ack", frame_done, 32'd0);
    endtask

    function automatic int pick_ex(input int n);
        int r = $urandom_range(2);
        if (r == 0) return 0;
        else if (r == 1) return n;
        else return $urandom_range(80, 1);
    endfunction

    int cur_n, cur_ex, nxt_n, nxt_ex, acc, budget;

    initial begin
        repeat (3) @(posedge clk);
        #1 areset = 1'b0;
        @(negedge clk);
        check_reset_values();

        // Nominal 16-beat frame
        arm_frame(16);
        send_frame(16, -1, 0, 1'b0, 32'h1000);
        wait_done();
        hold_and_read(5);
        ack_frame(1'b0, 0);

        // IDLE must not accept beats
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; tvalid = 1'b1; tdata = 32'hBAD0_0000 + i;
            @(negedge clk);
            check("tready_idle", tready, 32'd0);
        end
        @(posedge clk); #1; tvalid = 1'b0;
        @(negedge clk);
        check("len_hold_idle", frame_len, 32'd16);

        // Short frame, overflow frames, exact-depth frame, partial tkeep
        arm_frame(16);
        send_frame(12, -1, 10, 1'b1, 32'd0);
        wait_done(); hold_and_read(-1); ack_frame(1'b1, 0);
        send_frame(70, -1, 20, 1'b1, 32'd0);
        wait_done(); hold_and_read(-1); ack_frame(1'b1, 64);
        send_frame(64, -1, 40, 1'b1, 32'd0);
        wait_done(); hold_and_read(-1); ack_frame(1'b1, 65);
        send_frame(65, -1, 0, 1'b1, 32'd0);
        wait_done(); hold_and_read(-1); ack_frame(1'b1, 10);
        send_frame(10, 2, 0, 1'b1, 32'd0);
        wait_done(); hold_and_read(-1); ack_frame(1'b0, 0);

        // Random frames, some chained with ack+arm in the same cycle
        cur_n = $urandom_range(80, 1);
        cur_ex = pick_ex(cur_n);
        arm_frame(cur_ex);
        for (int k = 0; k < 8; k++) begin
            send_frame(cur_n, ($urandom_range(3) == 0) ? $urandom_range(cur_n - 1) : -1,
                       $urandom_range(50), 1'b1, 32'd0);
            wait_done();
            hold_and_read(-1);
            nxt_n = $urandom_range(80, 1);
            nxt_ex = pick_ex(nxt_n);
            if (k == 7) ack_frame(1'b0, 0);
            else if ($urandom_range(1) == 1) ack_frame(1'b1, nxt_ex);
            else begin ack_frame(1'b0, 0); arm_frame(nxt_ex); end
            cur_n = nxt_n; cur_ex = nxt_ex;
        end

        // Reset while the fifth beat of a frame is on the bus
        arm_frame(10);
        acc = 0; budget = 0;
        while (acc < 4 && budget < 100) begin
            @(posedge clk); #1; tvalid = 1'b1; tdata = 32'hC0DE_0000 + acc; tlast = 1'b0;
            @(negedge clk);
            if (tready) acc++;
            budget++;
        end
        @(posedge clk); #1; tdata = 32'hC0DE_0004; areset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1; areset = 1'b0; tvalid = 1'b0;
        fc_m = 16'd0; ec_m = 16'd0;
        @(negedge clk);
        check("tready_post_rst", tready, 32'd0);

        // Recovery frame after reset
        arm_frame(8);
        send_frame(8, -1, 25, 1'b1, 32'd0);
        wait_done(); hold_and_read(-1); ack_frame(1'b0, 0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("frames_drained", fr_q.size(), 32'd0);
        check("reads_drained", rd_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
